// File: rtl/fea_pkg.sv
// Shared definitions for the FEA node-chain sequencer: command codes,
// sequencer state type and small width helpers.
package fea_pkg;

    // Node command encodings (codes 4..7 are reserved)
    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_SET_NODE = 3'd1;
    localparam logic [2:0] CMD_CALC     = 3'd2;
    localparam logic [2:0] CMD_UPDATE   = 3'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CALC   = 3'd2,
        UPDATE = 3'd3,
        FINISH = 3'd4
    } fea_state_t;

    // Counter width able to index 0..n-1, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fea_step_timer.sv
// Settle counter plus completed-timestep counter for the FEA sequencer.
// Flags the last CALC cycle of a timestep and the UPDATE that ends the run.
module fea_step_timer
    import fea_pkg::*;
#(
    parameter int unsigned ITER_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,       // accepted start: restart both counters
    input  logic              i_calc,        // a CALC edge is being issued
    input  logic              i_update,      // an UPDATE edge is being issued
    input  logic [ITER_W-1:0] i_num_steps,   // latched timestep target
    output logic              o_settle_last, // this CALC edge is the last of the timestep
    output logic              o_step_term,   // this UPDATE completes the run
    output logic [ITER_W-1:0] o_step_count
);

    localparam int unsigned SET_W = idx_width(SETTLE_CYCLES);

    logic [SET_W-1:0]  r_settle;
    logic [ITER_W-1:0] r_step;
    logic [ITER_W-1:0] w_step_next;

    assign w_step_next   = r_step + ITER_W'(1);
    assign o_settle_last = (r_settle == SET_W'(SETTLE_CYCLES - 1));
    // Exact-width equality on the incremented value, so a target of all ones
    // is reached before the counter could wrap
    assign o_step_term   = (w_step_next == i_num_steps);
    assign o_step_count  = r_step;

    // Settle counter advances per CALC edge; step counter per UPDATE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_step   <= '0;
        end else if (i_clear) begin
            r_settle <= '0;
            r_step   <= '0;
        end else if (i_update) begin
            r_settle <= '0;
            r_step   <= w_step_next;
        end else if (i_calc && !o_settle_last) begin
            r_settle <= r_settle + SET_W'(1);
        end
    end

endmodule

// File: rtl/fea_sequencer.sv
// Sequencer for a chain of FEA node datapaths: loads one initial value per
// node, then runs the requested number of CALC/UPDATE timesteps.
module fea_sequencer
    import fea_pkg::*;
#(
    parameter int unsigned NUM_NODES     = 3,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ITER_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ITER_W-1:0]    num_steps,
    input  logic [WIDTH-1:0]     init_data,
    input  logic                 init_valid,
    output logic                 init_ready,
    output logic [2:0]           command,
    output logic [WIDTH-1:0]     set_val,
    output logic [NUM_NODES-1:0] node_en,
    output logic [ITER_W-1:0]    step_count,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IDX_W = idx_width(NUM_NODES);

    fea_state_t           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [ITER_W-1:0]    r_num_steps;
    logic [2:0]           r_command;
    logic [WIDTH-1:0]     r_set_val;
    logic [NUM_NODES-1:0] r_node_en;
    logic                 r_done;

    logic w_clear;
    logic w_calc;
    logic w_update;
    logic w_settle_last;
    logic w_step_term;
    logic w_beat;
    logic w_last_node;

    assign init_ready  = (r_state == LOAD) && !abort;
    assign busy        = (r_state != IDLE);
    assign w_beat      = init_valid && init_ready;
    assign w_last_node = (r_idx == IDX_W'(NUM_NODES - 1));

    assign w_clear  = (r_state == IDLE) && start;
    assign w_calc   = (r_state == CALC) && !abort;
    assign w_update = (r_state == UPDATE) && !abort;

    assign command = r_command;
    assign set_val = r_set_val;
    assign node_en = r_node_en;
    assign done    = r_done;

    fea_step_timer #(
        .ITER_W        (ITER_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_clear),
        .i_calc        (w_calc),
        .i_update      (w_update),
        .i_num_steps   (r_num_steps),
        .o_settle_last (w_settle_last),
        .o_step_term   (w_step_term),
        .o_step_count  (step_count)
    );

    // Run FSM with registered command, set_val, node_en and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_num_steps <= '0;
            r_command   <= CMD_NOP;
            r_set_val   <= '0;
            r_node_en   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && abort) begin
                // Abort outranks every other transition; step_count holds
                r_state   <= IDLE;
                r_command <= CMD_NOP;
                r_node_en <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_command <= CMD_NOP;
                        r_node_en <= '0;
                        if (start) begin
                            r_num_steps <= num_steps;
                            r_idx       <= '0;
                            r_state     <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (w_beat) begin
                            r_command <= CMD_SET_NODE;
                            r_set_val <= init_data;
                            r_node_en <= NUM_NODES'(1) << r_idx;
                            if (w_last_node) begin
                                r_idx   <= '0;
                                r_state <= (r_num_steps == '0) ? FINISH : CALC;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end else begin
                            r_command <= CMD_NOP;
                            r_node_en <= '0;
                        end
                    end
                    CALC: begin
                        r_command <= CMD_CALC;
                        r_node_en <= '1;
                        if (w_settle_last) begin
                            r_state <= UPDATE;
                        end
                    end
                    UPDATE: begin
                        r_command <= CMD_UPDATE;
                        r_node_en <= '1;
                        r_state   <= w_step_term ? FINISH : CALC;
                    end
                    FINISH: begin
                        r_done    <= 1'b1;
                        r_command <= CMD_NOP;
                        r_node_en <= '0;
                        r_state   <= IDLE;
                    end
                    default: begin
                        r_command <= CMD_NOP;
                        r_node_en <= '0;
                        r_state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fea_sequencer.sv
// Bench for fea_sequencer: directed scenarios with literal expectations plus
// randomized runs checked every cycle against a run-position model.
module tb_fea_sequencer;

    localparam int NN = 3;
    localparam int WD = 32;
    localparam int IW = 16;
    localparam int SC = 2;
    localparam int P  = SC + 1;   // cycles per timestep

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] num_steps = '0;
    logic [WD-1:0] init_data = '0;
    logic          init_valid = 1'b0;
    logic          init_ready;
    logic [2:0]    command;
    logic [WD-1:0] set_val;
    logic [NN-1:0] node_en;
    logic [IW-1:0] step_count;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    fea_sequencer #(
        .NUM_NODES     (NN),
        .WIDTH         (WD),
        .ITER_W        (IW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_steps  (num_steps),
        .init_data  (init_data),
        .init_valid (init_valid),
        .init_ready (init_ready),
        .command    (command),
        .set_val    (set_val),
        .node_en    (node_en),
        .step_count (step_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Run-position model: a run is "loaded k of N nodes" then "t cycles into
    // the compute phase", where cycle t is UPDATE iff t mod (SC+1) == SC.
    int          m_active = 0;
    int          m_loaded = 0;
    int          m_t = 0;
    int          m_nsteps = 0;
    int          m_step = 0;
    logic [2:0]  m_cmd = 3'd0;
    logic [WD-1:0] m_val = '0;
    logic [NN-1:0] m_en = '0;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_loaded = 0; m_t = 0; m_step = 0;
            m_cmd = 3'd0; m_val = '0; m_en = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active == 0) begin
                m_cmd = 3'd0; m_en = '0;
                if (start) begin
                    m_active = 1; m_loaded = 0; m_t = 0; m_step = 0;
                    m_nsteps = int'(num_steps);
                end
            end else if (abort) begin
                m_active = 0; m_cmd = 3'd0; m_en = '0;
            end else if (m_loaded < NN) begin
                if (init_valid) begin
                    m_cmd = 3'd1; m_val = init_data;
                    m_en = NN'(1 << m_loaded);
                    m_loaded++;
                end else begin
                    m_cmd = 3'd0; m_en = '0;
                end
            end else if (m_t < m_nsteps * P) begin
                if ((m_t % P) < SC) begin
                    m_cmd = 3'd2;
                end else begin
                    m_cmd = 3'd3;
                    m_step = m_t / P + 1;
                end
                m_en = '1;
                m_t++;
            end else begin
                m_done = 1'b1; m_cmd = 3'd0; m_en = '0; m_active = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("command", 64'(command), 64'(m_cmd));
            chk("node_en", 64'(node_en), 64'(m_en));
            chk("step_count", 64'(step_count), 64'(IW'(m_step)));
            chk("done", 64'(done), 64'(m_done));
            chk("busy", 64'(busy), 64'(m_active != 0));
            chk("init_ready", 64'(init_ready), 64'(m_active != 0 && m_loaded < NN && !abort));
            if (m_cmd == 3'd1) chk("set_val", 64'(set_val), 64'(m_val));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic begin_run(input int ns);
        start = 1'b1; num_steps = IW'(ns);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin seen = 1; break; end
            tick();
        end
        chk("done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wait_idle(input int limit);
        bit idle = 0;
        for (int i = 0; i < limit; i++) begin
            if (!busy) begin idle = 1; break; end
            tick();
        end
        chk("idle_timeout", 64'(idle), 64'd1);
    endtask

    initial begin
        int lit_cmd [11];
        int lit_step[11];
        int lit_done[11];
        int lit_en  [11];
        int st_v [7];
        int st_d [7];
        int st_en[7];

        lit_cmd  = '{1, 1, 1, 2, 2, 3, 2, 2, 3, 0, 0};
        lit_step = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2};
        lit_done = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        lit_en   = '{1, 2, 4, 7, 7, 7, 7, 7, 7, 0, 0};
        st_v  = '{1, 0, 0, 0, 0, 1, 1};
        st_d  = '{11, 0, 0, 0, 0, 22, 33};
        st_en = '{1, 0, 0, 0, 0, 2, 4};

        #12;
        chk("reset_command", 64'(command), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_step", 64'(step_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // Nominal: 3 nodes, 2 steps, data 10/20/30 offered continuously
        begin_run(2);
        chk("nom_load_nop", 64'(command), 64'd0);
        for (int i = 0; i < 11; i++) begin
            init_valid = (i < 3);
            init_data  = WD'((i + 1) * 10);
            tick();
            chk("nom_cmd", 64'(command), 64'(lit_cmd[i]));
            chk("nom_en", 64'(node_en), 64'(lit_en[i]));
            chk("nom_step", 64'(step_count), 64'(lit_step[i]));
            chk("nom_done", 64'(done), 64'(lit_done[i]));
            if (i < 3) chk("nom_val", 64'(set_val), 64'((i + 1) * 10));
        end
        chk("nom_busy_end", 64'(busy), 64'd0);

        // Init stall of four cycles between beats 1 and 2
        begin_run(1);
        for (int i = 0; i < 7; i++) begin
            init_valid = st_v[i][0];
            init_data  = WD'(st_d[i]);
            tick();
            chk("stall_cmd", 64'(command), 64'(st_v[i]));
            chk("stall_en", 64'(node_en), 64'(st_en[i]));
            if (st_v[i] != 0) chk("stall_val", 64'(set_val), 64'(st_d[i]));
        end
        init_valid = 1'b0;
        wait_done(20);
        chk("stall_step", 64'(step_count), 64'd1);
        tick();

        // Zero steps: loads then finishes directly
        begin_run(0);
        init_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            init_data = WD'(100 + i);
            tick();
            chk("zero_set", 64'(command), 64'd1);
        end
        init_valid = 1'b0;
        tick();
        chk("zero_cmd", 64'(command), 64'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_step", 64'(step_count), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);
        tick();

        // Abort during the first timestep, then a full fresh run
        begin_run(2);
        init_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            init_data = WD'(i);
            tick();
        end
        init_valid = 1'b0;
        tick();
        chk("abort_pre_calc", 64'(command), 64'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cmd", 64'(command), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_step", 64'(step_count), 64'd0);
        tick();
        begin_run(2);
        init_valid = 1'b1;
        tick(); tick(); tick();
        init_valid = 1'b0;
        wait_done(30);
        chk("rerun_step", 64'(step_count), 64'd2);
        tick();

        // Start while busy is ignored
        begin_run(1);
        init_valid = 1'b1;
        tick(); tick(); tick();
        init_valid = 1'b0;
        tick();
        start = 1'b1; num_steps = IW'(5);
        tick();
        start = 1'b0;
        wait_done(30);
        chk("busy_start_step", 64'(step_count), 64'd1);
        tick();
        chk("busy_start_idle", 64'(busy), 64'd0);

        // Randomized runs with stalls, stray starts, aborts and one async reset
        for (int r = 0; r < 40; r++) begin
            begin_run($urandom_range(0, 4));
            for (int c = 0; c < 40; c++) begin
                init_valid = ($urandom_range(0, 9) < 7);
                init_data  = WD'($urandom);
                abort      = ($urandom_range(0, 79) == 0);
                start      = ($urandom_range(0, 24) == 0);
                num_steps  = IW'($urandom_range(0, 4));
                if (r == 20 && c == 9) begin
                    #1 rst_n = 1'b0;
                    #1;
                    chk("async_cmd", 64'(command), 64'd0);
                    chk("async_en", 64'(node_en), 64'd0);
                    chk("async_busy", 64'(busy), 64'd0);
                    chk("async_done", 64'(done), 64'd0);
                    chk("async_step", 64'(step_count), 64'd0);
                    chk("async_val", 64'(set_val), 64'd0);
                    start = 1'b0; abort = 1'b0; init_valid = 1'b0;
                    #1 rst_n = 1'b1;
                end
                tick();
            end
            start = 1'b0; abort = 1'b0;
            init_valid = 1'b1;
            wait_idle(60);
            init_valid = 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
